// File: rtl/serial_subtractor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | serial_subtractor                                                         |
// | Bit-serial unsigned a - b, LSB first, one bit per clock, borrow-out flag. |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] c_LAST = CW'(WIDTH - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [CW-1:0]    r_cnt;
    logic             r_bin;
    logic             w_d;
    logic             w_bout;
    logic             w_last;

    // Full subtractor on the current LSBs of the working registers
    assign w_d    = r_a[0] ^ r_b[0] ^ r_bin;
    assign w_bout = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_bin);
    assign w_last = (r_cnt == c_LAST);

    assign busy = (r_state != c_IDLE);
    assign done = (r_state == c_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:  if (start) w_next = c_RUN;
            c_RUN:   if (w_last) w_next = c_DONE;
            c_DONE:  w_next = c_IDLE;
            default: w_next = c_IDLE;
        endcase
    end

    // Outputs only load on the final bit, so they stay frozen during RUN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_res  <= '0;
            r_cnt  <= '0;
            r_bin  <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_res <= '0;
                        r_cnt <= '0;
                        r_bin <= 1'b0;
                    end
                end
                c_RUN: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_bin <= w_bout;
                    r_res <= {w_d, r_res[WIDTH-1:1]};
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        diff   <= {w_d, r_res[WIDTH-1:1]};
                        borrow <= w_bout;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_serial_subtractor                                                      |
// | Directed self-checking bench for serial_subtractor (WIDTH = 8).           |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_serial_subtractor;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One start pulse, scrambled operands afterwards, bounded wait for done
    task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_op,
                         input logic [7:0] ed, input logic eb, input string tag);
        int k;
        logic [7:0] held;
        held = diff;
        @(negedge clk);
        a = ta; b = tb_op; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = 8'hA5; b = 8'h3C;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        k = 0;
        while (!done && k < 20) begin
            @(negedge clk);
            k++;
            if (k == 4) check({tag, "_hold"}, 32'(diff), 32'(held));
        end
        check({tag, "_latency"}, 32'(k), 32'd8);
        check({tag, "_diff"}, 32'(diff), 32'(ed));
        check({tag, "_borrow"}, 32'(borrow), 32'(eb));
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
        check({tag, "_keep"}, 32'(diff), 32'(ed));
    endtask

    initial begin
        int ndone;
        int cyc;
        int idle_cnt;
        int t[8];
        logic [7:0] dcap;

        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_borrow", 32'(borrow), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        do_op(8'd100, 8'd37, 8'd63, 1'b0, "100_37");
        do_op(8'd5, 8'd9, 8'd252, 1'b1, "5_9");
        do_op(8'd0, 8'd0, 8'd0, 1'b0, "0_0");
        do_op(8'd255, 8'd255, 8'd0, 1'b0, "255_255");
        do_op(8'd0, 8'd1, 8'd255, 1'b1, "0_1");

        // Start during RUN is ignored and not queued
        @(negedge clk);
        a = 8'd50; b = 8'd20; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = '0; b = '0;
        @(negedge clk);
        @(negedge clk);
        a = 8'd7; b = 8'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0; dcap = '0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                dcap = diff;
            end
        end
        check("ignore_ndone", 32'(ndone), 32'd1);
        check("ignore_diff", 32'(dcap), 32'd30);

        // Reset mid-RUN aborts the operation
        @(negedge clk);
        a = 8'd200; b = 8'd100; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("prereset_diff", 32'(diff), 32'd30);
        #2 rst = 1'b1;
        #1;
        check("arst_diff", 32'(diff), 32'd0);
        check("arst_borrow", 32'(borrow), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("abort_ndone", 32'(ndone), 32'd0);
        do_op(8'd10, 8'd4, 8'd6, 1'b0, "10_4");

        // Start held high: back-to-back operations every WIDTH+2 cycles
        @(negedge clk);
        a = 8'd9; b = 8'd2; start = 1'b1;
        ndone = 0; idle_cnt = 0;
        for (cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (done) begin
                if (ndone < 8) t[ndone] = cyc;
                ndone++;
                check("b2b_diff", 32'(diff), 32'd7);
            end else if (!busy && ndone == 1) begin
                idle_cnt++;
            end
        end
        start = 1'b0;
        check("b2b_ndone", 32'(ndone >= 3), 32'd1);
        check("b2b_period1", 32'(t[1] - t[0]), 32'(WIDTH + 2));
        check("b2b_period2", 32'(t[2] - t[1]), 32'(WIDTH + 2));
        check("b2b_idle", 32'(idle_cnt), 32'd1);
        repeat (12) @(negedge clk);
        check("final_idle", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
